// File: rtl/collision_record_reader_if.sv
// collision_record_reader_if
//   Bundles the pass control, RAM read port and record hand-off signals of
//   collision_record_reader.
//   master : the reader (drives RAM address/strobes, record words, status)
//   slave  : the environment (drives start/base/count, RAM data, rec_ready)
//
//   Handshake: a record transfers on a rising edge where rec_valid=1 and
//   rec_ready=1. While rec_valid=1 the reader holds rec0..rec6 and rec_index
//   stable. rec_ready has no effect while rec_valid=0.
interface collision_record_reader_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
);
  logic                  start;
  logic [ADDR_WIDTH-1:0] base_addr;
  logic [ADDR_WIDTH-1:0] rec_count;
  logic [ADDR_WIDTH-1:0] ram_addressout;
  logic                  ram_cs;
  logic                  ram_oe;
  logic                  ram_we;
  logic [DATA_WIDTH-1:0] ram_dataout;
  logic [DATA_WIDTH-1:0] rec0;
  logic [DATA_WIDTH-1:0] rec1;
  logic [DATA_WIDTH-1:0] rec2;
  logic [DATA_WIDTH-1:0] rec3;
  logic [DATA_WIDTH-1:0] rec4;
  logic [DATA_WIDTH-1:0] rec5;
  logic [DATA_WIDTH-1:0] rec6;
  logic [ADDR_WIDTH-1:0] rec_index;
  logic                  rec_valid;
  logic                  rec_ready;
  logic                  busy;
  logic                  done;

  modport master (
    input  start, base_addr, rec_count, ram_dataout, rec_ready,
    output ram_addressout, ram_cs, ram_oe, ram_we,
    output rec0, rec1, rec2, rec3, rec4, rec5, rec6,
    output rec_index, rec_valid, busy, done
  );

  modport slave (
    output start, base_addr, rec_count, ram_dataout, rec_ready,
    input  ram_addressout, ram_cs, ram_oe, ram_we,
    input  rec0, rec1, rec2, rec3, rec4, rec5, rec6,
    input  rec_index, rec_valid, busy, done
  );
endinterface

// File: rtl/collision_record_reader.sv
// collision_record_reader
//   Reads up to MAX_REC body records of WORDS_PER_REC words each out of a
//   synchronous state RAM (one-cycle read latency), reassembles each record
//   into rec0..rec6 and presents it with a valid/ready hand-off.
//
// Ports
//   clk       : single clock, rising edge
//   rst_n     : synchronous active-low reset
//   bus       : collision_record_reader_if.master
//               start/base_addr/rec_count  pass request (sampled in IDLE)
//               ram_addressout/cs/oe/we     RAM read port (we tied low)
//               ram_dataout                 RAM read data
//               rec0..rec6/rec_index        presented record
//               rec_valid/rec_ready         record hand-off
//               busy/done                   pass status
//   state_dbg : current FSM state encoding (IDLE=0 READ=1 WAIT=2
//               PRESENT=3 DONE=4)
//
// Timing of one record: READ issues word addresses k=0..6 on consecutive
// cycles, WAIT lets the last word return, PRESENT holds the record until it
// is accepted. Word k is captured two edges after its address appears
// (one edge for the RAM, one for the capture register), so word 6 lands on
// the WAIT edge together with rec_valid.
module collision_record_reader #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDR_WIDTH    = 32,
  parameter int WORDS_PER_REC = 7,
  parameter int MAX_REC       = 12
) (
  input  logic                       clk,
  input  logic                       rst_n,
  collision_record_reader_if.master  bus,
  output logic [2:0]                 state_dbg
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_READ    = 3'd1,
    S_WAIT    = 3'd2,
    S_PRESENT = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  localparam logic [2:0]            K_LAST = 3'(WORDS_PER_REC - 1);
  localparam logic [ADDR_WIDTH-1:0] STRIDE = ADDR_WIDTH'(WORDS_PER_REC);
  localparam logic [ADDR_WIDTH-1:0] N_MAX  = ADDR_WIDTH'(MAX_REC);

  state_t state_q, state_d;

  // Pass context. rec_base_q tracks base + WORDS_PER_REC*i incrementally so
  // the address path is a single adder (wraps modulo 2^ADDR_WIDTH).
  logic [ADDR_WIDTH-1:0] rec_base_q;
  logic [ADDR_WIDTH-1:0] n_q;
  logic [ADDR_WIDTH-1:0] i_q;
  logic [2:0]            k_q;

  // One-cycle delayed copy of the read strobe and word counter: marks which
  // rec word the RAM data present this cycle belongs to.
  logic                  pend_valid_q;
  logic [2:0]            pend_k_q;

  logic [DATA_WIDTH-1:0] rec_q [7];
  logic [ADDR_WIDTH-1:0] rec_index_q;
  logic                  rec_valid_q;

  logic [ADDR_WIDTH-1:0] n_in;
  logic                  load;
  logic                  k_step;
  logic                  set_valid;
  logic                  accept;
  logic                  last_rec;

  assign n_in     = (bus.rec_count > N_MAX) ? N_MAX : bus.rec_count;
  assign last_rec = ((i_q + ADDR_WIDTH'(1)) == n_q);

  // Next-state and control strobes.
  always_comb begin
    state_d   = state_q;
    load      = 1'b0;
    k_step    = 1'b0;
    set_valid = 1'b0;
    accept    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          load    = 1'b1;
          state_d = (n_in == '0) ? S_DONE : S_READ;
        end
      end
      S_READ: begin
        k_step = 1'b1;
        if (k_q == K_LAST) state_d = S_WAIT;
      end
      S_WAIT: begin
        set_valid = 1'b1;
        state_d   = S_PRESENT;
      end
      S_PRESENT: begin
        // rec_valid is always 1 in PRESENT, so rec_ready alone accepts.
        if (bus.rec_ready) begin
          accept  = 1'b1;
          state_d = last_rec ? S_DONE : S_READ;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      rec_base_q   <= '0;
      n_q          <= '0;
      i_q          <= '0;
      k_q          <= '0;
      pend_valid_q <= 1'b0;
      pend_k_q     <= '0;
      rec_index_q  <= '0;
      rec_valid_q  <= 1'b0;
      for (int w = 0; w < 7; w++) rec_q[w] <= '0;
    end else begin
      state_q      <= state_d;
      pend_valid_q <= (state_q == S_READ);
      pend_k_q     <= k_q;

      if (load) begin
        rec_base_q <= bus.base_addr;
        n_q        <= n_in;
        i_q        <= '0;
        k_q        <= '0;
      end

      if (k_step) begin
        k_q <= (k_q == K_LAST) ? 3'd0 : k_q + 3'd1;
      end

      if (pend_valid_q) begin
        for (int w = 0; w < 7; w++) begin
          if (pend_k_q == 3'(w)) rec_q[w] <= bus.ram_dataout;
        end
      end

      if (set_valid) begin
        rec_valid_q <= 1'b1;
        rec_index_q <= i_q;
      end

      if (accept) begin
        rec_valid_q <= 1'b0;
        k_q         <= '0;
        if (!last_rec) begin
          i_q        <= i_q + ADDR_WIDTH'(1);
          rec_base_q <= rec_base_q + STRIDE;
        end
      end
    end
  end

  assign bus.ram_addressout = (state_q == S_READ) ? rec_base_q + ADDR_WIDTH'(k_q) : '0;
  assign bus.ram_cs         = (state_q == S_READ);
  assign bus.ram_oe         = (state_q == S_READ);
  assign bus.ram_we         = 1'b0;

  assign bus.rec0      = rec_q[0];
  assign bus.rec1      = rec_q[1];
  assign bus.rec2      = rec_q[2];
  assign bus.rec3      = rec_q[3];
  assign bus.rec4      = rec_q[4];
  assign bus.rec5      = rec_q[5];
  assign bus.rec6      = rec_q[6];
  assign bus.rec_index = rec_index_q;
  assign bus.rec_valid = rec_valid_q;
  assign bus.busy      = (state_q != S_IDLE);
  assign bus.done      = (state_q == S_DONE);
  assign state_dbg     = state_q;

endmodule
